dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data memory (D_MEM: asynchronous read, write on clk rising edge) between two requesters:
  - Memory-stage CPU port (priority requester).
  - Secondary DMA/loader port (used by the program loader and debug).
- The CPU normally wins. A saturating starvation counter forces one DMA grant after MAX_WAIT lost cycles, and the arbiter stalls the pipeline for that cycle.
- Sits between Mem stage and D_MEM. The cpu_stall output feeds the hazard unit, which freezes the F/D/E/M pipeline registers.

Parameters:
- ADDR_W, 32, address width of both ports and memory.
- DATA_W, 32, data width.
- MAX_WAIT, 4, number of consecutive lost DMA cycles before a forced DMA grant (legal range 1..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  Mem stage accesses memory this cycle (load or store).
- cpu_we  in  1  CPU store (1) / load (0).
- cpu_addr  in  ADDR_W  CPU address (ALU result).
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_rdata  out  DATA_W  CPU load data (combinational from mem_rdata).
- cpu_stall  out  1  CPU access not performed this cycle; pipeline must hold.
- dma_req  in  1  DMA request, held until granted.
- dma_we  in  1  DMA write (1) / read (0).
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_gnt  out  1  DMA access performed this cycle.
- dma_rdata  out  DATA_W  registered DMA read data.
- dma_rvalid  out  1  one-cycle pulse; dma_rdata is valid.
- mem_we  out  1  D_MEM write enable (MemRW).
- mem_addr  out  ADDR_W  D_MEM address.
- mem_wdata  out  DATA_W  D_MEM write data.
- mem_rdata  in  DATA_W  D_MEM read data.

Behaviour:
- State:
  - wait_cnt: CNT_W bits, enough to hold MAX_WAIT.
  - dma_rdata register.
  - dma_rvalid register.
- Reset (asynchronous):
  - wait_cnt=0, dma_rdata=0, dma_rvalid=0.
  - While rst_n=0, dma_gnt=0, cpu_stall=0, mem_we=0.
  - A reset in the middle of a DMA wait discards the pending count. The DMA requester keeps dma_req asserted.
- Grant (combinational, per cycle):
  - force = dma_req & (wait_cnt == MAX_WAIT).
  - dma_gnt = dma_req & (~cpu_req | force).
  - cpu_stall = cpu_req & dma_gnt.
- Memory mux:
  - If dma_gnt: mem_addr/mem_wdata/mem_we come from the DMA port.
  - Else: they come from the CPU port, and mem_we = cpu_req & cpu_we.
  - With no requester, mem_we=0 and mem_addr=cpu_addr.
- cpu_rdata = mem_rdata always. It is meaningful only when cpu_req & ~cpu_stall.
- Starvation counter, updated on the clk edge:
  - dma_req=0 or dma_gnt=1: wait_cnt <= 0.
  - dma_req=1, dma_gnt=0: wait_cnt <= wait_cnt+1, saturating at MAX_WAIT.
- Forced-grant latency:
  - With cpu_req held high continuously, a DMA request asserted in cycle 0 is granted in cycle MAX_WAIT.
  - That is, exactly MAX_WAIT stall-free CPU cycles, then one stall cycle.
  - The counter then clears, so the CPU is guaranteed MAX_WAIT accesses between forced stalls.
- DMA read return:
  - Edge following a cycle with dma_gnt & ~dma_we: dma_rdata <= mem_rdata, dma_rvalid <= 1.
  - Otherwise dma_rvalid <= 0 and dma_rdata holds.
- DMA write completes at the granted clk edge. No acknowledge beyond dma_gnt.
- Handshake: DMA master drops or changes its request only after the cycle in which dma_gnt=1. Back-to-back DMA grants are legal when cpu_req=0.
- Simultaneous events:
  - In a forced cycle, the CPU store is suppressed (mem_we follows dma_we only).
  - The CPU re-presents the same access next cycle because its pipeline register held.
- No combinational path from cpu_stall back to any input.

Decomposition:
- Shared package (dmem_pkg):
  - ADDR_W/DATA_W defaults.
  - localparam function for CNT_W (clog2(MAX_WAIT+1)).
  - Grant-source enum GNT_CPU/GNT_DMA used for the mux select.
- One natural sub-module: starve_counter (saturating counter with clear, count-enable and at_max output), reusable by a future I-mem arbiter.
- Grant logic and mux stay in dmem_arbiter.

Test Plan:
- Only cpu_req=1, cpu_we=1, addr 0x10, wdata 0xDEADBEEF → mem_we=1 and mem_addr=0x10 same cycle; cpu_stall=0, dma_gnt=0 throughout.
- Only dma_req=1, dma_we=0, addr 0x20 (mem holds 0x12345678) → dma_gnt=1 same cycle; next cycle dma_rvalid=1, dma_rdata=0x12345678; following cycle dma_rvalid=0.
- cpu_req held 1, dma_req held 1 from cycle 0, MAX_WAIT=4 → cycles 0–3: dma_gnt=0, cpu_stall=0; cycle 4: dma_gnt=1, cpu_stall=1; cycles 5–8: CPU wins again.
- Forced cycle with cpu_we=1 to 0x30 and dma_we=0 → no write to 0x30 in the stall cycle; write occurs the next cycle when the CPU retries.
- rst_n pulsed low mid-wait (wait_cnt=3) → dma_rvalid=0, dma_gnt=0, mem_we=0 during reset; after release the forced grant again needs 4 full lost cycles.
- cpu_req=0, dma_req held 1 for 3 writes to 0x40/0x44/0x48 → dma_gnt=1 on 3 consecutive cycles; all three memory words updated.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and related arbitration blocks.
//   ADDR_W_DEF/DATA_W_DEF : default bus widths
//   cnt_w()               : width needed to hold a wait count of 0..max_wait
//   gnt_src_e             : memory mux select (which port owns D_MEM this cycle)
package dmem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // Bits needed to represent 0..max_wait inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_wait);
    return $clog2(max_wait + 1);
  endfunction

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } gnt_src_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating starvation counter.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   clr        : synchronous clear, wins over inc
//   inc        : count one lost cycle, saturating at MAX
//   at_max     : count equals MAX
module starve_counter #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  logic [W-1:0] cnt;

  assign at_max = (cnt == W'(MAX));

  // Count lost cycles; hold once saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the Mem-stage CPU port (priority) and a DMA/loader
// port. A starvation counter forces one DMA grant after MAX_WAIT lost cycles,
// stalling the CPU for that cycle.
//   cpu_*      : CPU access (req/we/addr/wdata in, rdata/stall out)
//   dma_*      : DMA access (req/we/addr/wdata in, gnt/rdata/rvalid out)
//   mem_*      : D_MEM side (async read data in, addr/wdata/we out)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = cnt_w(MAX_WAIT);

  logic     at_max;
  logic     force_gnt;
  gnt_src_e gnt_src;

  // Lost-cycle counter: cleared when DMA idles or wins, counts while it loses.
  starve_counter #(
    .MAX (MAX_WAIT),
    .W   (CNT_W)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (~dma_req | dma_gnt),
    .inc    (dma_req & ~dma_gnt),
    .at_max (at_max)
  );

  // Grant: DMA wins when CPU is idle or when starvation forces it.
  // rst_n gating keeps the grant and writes quiet while reset is held.
  assign force_gnt = dma_req & at_max;
  assign dma_gnt   = rst_n & dma_req & (~cpu_req | force_gnt);
  assign cpu_stall = cpu_req & dma_gnt;
  assign gnt_src   = dma_gnt ? GNT_DMA : GNT_CPU;

  // Memory mux; a forced cycle suppresses the CPU store, which is replayed next cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    case (gnt_src)
      GNT_DMA: begin
        mem_we    = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end
      default: begin
        mem_we    = rst_n & cpu_req & cpu_we;
      end
    endcase
  end

  assign cpu_rdata = mem_rdata;

  // Capture DMA read data on the edge closing a granted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_rdata  <= '0;
      dma_rvalid <= 1'b0;
    end else begin
      dma_rvalid <= dma_gnt & ~dma_we;
      if (dma_gnt && !dma_we) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural D_MEM model.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dma_gnt, dma_rvalid, mem_we;

  int checks;
  int errors;

  logic [31:0] mem [0:255];

  dmem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // D_MEM: async read, write on rising edge
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  typedef struct packed {
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        exp_gnt;
    logic        exp_stall;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [0:7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wd;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h08] = 32'h12345678;  // 0x20
    mem[8'h09] = 32'h0BADF00D;  // 0x24

    //            creq cwe caddr         cwdata        dreq dwe daddr         dwdata        gnt st we addr          wdata         rv rdata
    vecs[0] = '{1'b1,1'b1,32'h10,32'hDEADBEEF,1'b0,1'b0,32'h0, 32'h0,  1'b0,1'b0,1'b1,32'h10,32'hDEADBEEF,1'b0,32'h0};
    vecs[1] = '{1'b1,1'b0,32'h14,32'h0,       1'b0,1'b0,32'h0, 32'h0,  1'b0,1'b0,1'b0,32'h14,32'h0,       1'b0,32'h0};
    vecs[2] = '{1'b0,1'b0,32'h18,32'h5,       1'b0,1'b0,32'h0, 32'h0,  1'b0,1'b0,1'b0,32'h18,32'h5,       1'b0,32'h0};
    vecs[3] = '{1'b1,1'b1,32'h1C,32'h11,      1'b1,1'b1,32'h50,32'h22, 1'b0,1'b0,1'b1,32'h1C,32'h11,      1'b0,32'h0};
    vecs[4] = '{1'b0,1'b0,32'h1C,32'h0,       1'b1,1'b1,32'h50,32'hAA, 1'b1,1'b0,1'b1,32'h50,32'hAA,      1'b0,32'h0};
    vecs[5] = '{1'b0,1'b1,32'h60,32'h77,      1'b1,1'b0,32'h20,32'h0,  1'b1,1'b0,1'b0,32'h20,32'h0,       1'b0,32'h0};
    vecs[6] = '{1'b0,1'b0,32'h20,32'h0,       1'b0,1'b0,32'h0, 32'h0,  1'b0,1'b0,1'b0,32'h20,32'h0,       1'b1,32'h12345678};
    vecs[7] = '{1'b0,1'b0,32'h20,32'h0,       1'b0,1'b0,32'h0, 32'h0,  1'b0,1'b0,1'b0,32'h20,32'h0,       1'b0,32'h12345678};

    // Reset: DMA request and write pending, everything must stay quiet
    rst_n = 1'b0;
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b1, 1'b1, 32'h40, 32'h99);
    #3;
    chk("reset dma_gnt", 32'(dma_gnt), 32'h0);
    chk("reset cpu_stall", 32'(cpu_stall), 32'h0);
    chk("reset mem_we", 32'(mem_we), 32'h0);
    chk("reset dma_rvalid", 32'(dma_rvalid), 32'h0);
    chk("reset dma_rdata", dma_rdata, 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // Table vectors (counter never reaches max here)
    for (int i = 0; i < 8; i++) begin
      set_cpu(vecs[i].cpu_req, vecs[i].cpu_we, vecs[i].cpu_addr, vecs[i].cpu_wdata);
      set_dma(vecs[i].dma_req, vecs[i].dma_we, vecs[i].dma_addr, vecs[i].dma_wdata);
      #1;
      chk($sformatf("v%0d dma_gnt", i), 32'(dma_gnt), 32'(vecs[i].exp_gnt));
      chk($sformatf("v%0d cpu_stall", i), 32'(cpu_stall), 32'(vecs[i].exp_stall));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
      chk($sformatf("v%0d dma_rvalid", i), 32'(dma_rvalid), 32'(vecs[i].exp_rvalid));
      chk($sformatf("v%0d dma_rdata", i), dma_rdata, vecs[i].exp_rdata);
      step();
    end
    chk("mem 0x10", mem[8'h04], 32'hDEADBEEF);
    chk("mem 0x1C", mem[8'h07], 32'h11);
    chk("mem 0x50", mem[8'h14], 32'hAA);

    // Starvation: CPU loads continuously, DMA read held from cycle 0
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    set_dma(1'b1, 1'b0, 32'h24, 32'h0);
    for (int c = 0; c < 9; c++) begin
      #1;
      chk($sformatf("starve c%0d dma_gnt", c), 32'(dma_gnt), 32'(c == 4));
      chk($sformatf("starve c%0d cpu_stall", c), 32'(cpu_stall), 32'(c == 4));
      chk($sformatf("starve c%0d dma_rvalid", c), 32'(dma_rvalid), 32'(c == 5));
      if (c == 0) chk("starve cpu_rdata", cpu_rdata, 32'hDEADBEEF);
      if (c == 5) chk("starve dma_rdata", dma_rdata, 32'h0BADF00D);
      step();
    end
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Forced cycle coinciding with a CPU store: store suppressed, then replayed
    set_dma(1'b1, 1'b0, 32'h24, 32'h0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("fst c%0d dma_gnt", c), 32'(dma_gnt), 32'h0);
      step();
    end
    set_cpu(1'b1, 1'b1, 32'h30, 32'hCAFE0030);
    #1;
    chk("fst forced cpu_stall", 32'(cpu_stall), 32'h1);
    chk("fst forced mem_we", 32'(mem_we), 32'h0);
    chk("fst forced mem_addr", mem_addr, 32'h24);
    step();
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("fst no write during stall", mem[8'h0C], 32'h0);
    chk("fst retry cpu_stall", 32'(cpu_stall), 32'h0);
    chk("fst retry mem_we", 32'(mem_we), 32'h1);
    chk("fst retry mem_addr", mem_addr, 32'h30);
    step();
    chk("fst write after retry", mem[8'h0C], 32'hCAFE0030);
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Reset in the middle of a DMA wait (count at 3)
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    set_dma(1'b1, 1'b0, 32'h24, 32'h0);
    for (int c = 0; c < 3; c++) step();
    #1;
    chk("rstmid pre dma_gnt", 32'(dma_gnt), 32'h0);
    cpu_we = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rstmid dma_gnt", 32'(dma_gnt), 32'h0);
    chk("rstmid cpu_stall", 32'(cpu_stall), 32'h0);
    chk("rstmid mem_we", 32'(mem_we), 32'h0);
    chk("rstmid dma_rvalid", 32'(dma_rvalid), 32'h0);
    chk("rstmid dma_rdata", dma_rdata, 32'h0);
    step();
    chk("rstmid held dma_gnt", 32'(dma_gnt), 32'h0);
    cpu_we = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("rstmid after c%0d dma_gnt", c), 32'(dma_gnt), 32'(c == 4));
      step();
    end
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Back-to-back DMA writes with CPU idle
    for (int k = 0; k < 3; k++) begin
      set_dma(1'b1, 1'b1, 32'h40 + 32'(4 * k), 32'hB0 + 32'(k));
      #1;
      chk($sformatf("burst%0d dma_gnt", k), 32'(dma_gnt), 32'h1);
      chk($sformatf("burst%0d mem_we", k), 32'(mem_we), 32'h1);
      chk($sformatf("burst%0d mem_addr", k), mem_addr, 32'h40 + 32'(4 * k));
      step();
    end
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("burst mem 0x40", mem[8'h10], 32'hB0);
    chk("burst mem 0x44", mem[8'h11], 32'hB1);
    chk("burst mem 0x48", mem[8'h12], 32'hB2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
